// File: rtl/usb_host_line_receiver_if.sv
// Bus between the USB line sampler and the host line receiver: bit-time strobe,
// raw {D+, D-} sample and control in, decoded serial stream and status pulses out.
interface usb_host_line_receiver_if;
  logic       bit_strobe;
  logic       rx_enable;
  logic       low_speed;
  logic [1:0] usb_line;
  logic       serial_data_out;
  logic       serial_data_out_val;
  logic       packet_start;
  logic       packet_end;
  logic       rx_active;
  logic       rx_error;
  logic       rx_timeout;

  // master: the side that owns the line sample and the receive window
  modport master (
    output bit_strobe, rx_enable, low_speed, usb_line,
    input  serial_data_out, serial_data_out_val, packet_start, packet_end,
           rx_active, rx_error, rx_timeout
  );

  // slave: the line receiver itself
  modport slave (
    input  bit_strobe, rx_enable, low_speed, usb_line,
    output serial_data_out, serial_data_out_val, packet_start, packet_end,
           rx_active, rx_error, rx_timeout
  );
endinterface

// File: rtl/usb_host_line_receiver.sv
// Host receive front end: SYNC detection, NRZI decode, bit unstuffing and
// SE0/SE0/J end-of-packet detection, emitting an LSB-first serial bit stream.
module usb_host_line_receiver #(
  parameter int SYNC_BITS    = 8,
  parameter int STUFF_LIMIT  = 6,
  parameter int TIMEOUT_BITS = 16,
  parameter int TMO_W        = 5
) (
  input logic                     clock,
  input logic                     reset,
  usb_host_line_receiver_if.slave bus
);

  localparam int SYNC_W = $clog2(SYNC_BITS + 1);
  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam int BIT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SYNC,
    S_SYNC,
    S_DATA,
    S_EOP1,
    S_EOP2,
    S_ERROR
  } state_e;

  state_e            state_q,     state_d;
  logic [1:0]        prev_line_q, prev_line_d;
  logic [ONES_W-1:0] ones_cnt_q,  ones_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q,   tmo_cnt_d;
  logic [SYNC_W-1:0] sync_cnt_q,  sync_cnt_d;
  logic              data_q,      data_d;
  logic              val_q,       val_d;
  logic              start_q,     start_d;
  logic              end_q,       end_d;
  logic              active_q,    active_d;
  logic              error_q,     error_d;
  logic              timeout_q,   timeout_d;

  logic [1:0]        j_line;
  logic [1:0]        k_line;
  logic              line_se0;
  logic              line_se1;
  logic              line_j;
  logic              line_k;
  logic              dec_bit;
  logic [SYNC_W-1:0] sync_idx;
  logic              fail;

  // Line classification; J/K polarity swaps between full and low speed.
  always_comb begin
    j_line   = bus.low_speed ? 2'b01 : 2'b10;
    k_line   = ~j_line;
    line_se0 = (bus.usb_line == 2'b00);
    line_se1 = (bus.usb_line == 2'b11);
    line_j   = (bus.usb_line == j_line);
    line_k   = (bus.usb_line == k_line);
    dec_bit  = (bus.usb_line == prev_line_q);
    sync_idx = sync_cnt_q + SYNC_W'(1);
  end

  // NOTE: every variable assigned below gets a default first, so no path
  // through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    prev_line_d = prev_line_q;
    ones_cnt_d  = ones_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    sync_cnt_d  = sync_cnt_q;
    data_d      = data_q;
    val_d       = 1'b0;
    start_d     = 1'b0;
    end_d       = 1'b0;
    active_d    = active_q;
    error_d     = 1'b0;
    timeout_d   = 1'b0;
    fail        = 1'b0;

    if (!bus.rx_enable) begin
      // Abort from any state, silently, regardless of a coincident strobe.
      state_d  = S_IDLE;
      active_d = 1'b0;
    end else if (state_q == S_IDLE) begin
      state_d     = S_WAIT_SYNC;
      tmo_cnt_d   = '0;
      prev_line_d = j_line;
    end else if (bus.bit_strobe) begin
      if (!line_se0) prev_line_d = bus.usb_line;

      case (state_q)
        S_WAIT_SYNC: begin
          if (line_k) begin
            state_d    = S_SYNC;
            sync_cnt_d = SYNC_W'(1);
          end else if (line_j) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            if (tmo_cnt_q == TMO_W'(TIMEOUT_BITS - 1)) begin
              timeout_d = 1'b1;
              state_d   = S_IDLE;
            end
          end else begin
            fail = 1'b1;
          end
        end

        S_SYNC: begin
          if (line_se0 || line_se1) begin
            fail = 1'b1;
          end else if (sync_idx == SYNC_W'(SYNC_BITS)) begin
            if (dec_bit) begin
              // The final SYNC 1 already counts toward the stuffing run.
              state_d    = S_DATA;
              start_d    = 1'b1;
              active_d   = 1'b1;
              ones_cnt_d = ONES_W'(1);
              bit_cnt_d  = '0;
            end else begin
              fail = 1'b1;
            end
          end else if (dec_bit) begin
            fail = 1'b1;
          end else begin
            sync_cnt_d = sync_idx;
          end
        end

        S_DATA: begin
          if (line_se0) begin
            state_d = S_EOP1;
          end else if (line_se1) begin
            fail = 1'b1;
          end else if (ones_cnt_q == ONES_W'(STUFF_LIMIT)) begin
            if (dec_bit) fail = 1'b1;
            else         ones_cnt_d = '0;
          end else begin
            data_d     = dec_bit;
            val_d      = 1'b1;
            ones_cnt_d = dec_bit ? ones_cnt_q + ONES_W'(1) : '0;
            if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end

        S_EOP1: begin
          if (line_se0) state_d = S_EOP2;
          else          fail    = 1'b1;
        end

        S_EOP2: begin
          if (line_j) begin
            state_d  = S_IDLE;
            active_d = 1'b0;
            if ((bit_cnt_q[2:0] == 3'd0) && (bit_cnt_q != '0)) end_d   = 1'b1;
            else                                                error_d = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end

        default: ;
      endcase

      if (fail) begin
        state_d  = S_ERROR;
        error_d  = 1'b1;
        active_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its _d input, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      prev_line_q <= j_line;
      ones_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      sync_cnt_q  <= '0;
      data_q      <= 1'b0;
      val_q       <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      active_q    <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_line_q <= prev_line_d;
      ones_cnt_q  <= ones_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      sync_cnt_q  <= sync_cnt_d;
      data_q      <= data_d;
      val_q       <= val_d;
      start_q     <= start_d;
      end_q       <= end_d;
      active_q    <= active_d;
      error_q     <= error_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.serial_data_out     = data_q;
  assign bus.serial_data_out_val = val_q;
  assign bus.packet_start        = start_q;
  assign bus.packet_end          = end_q;
  assign bus.rx_active           = active_q;
  assign bus.rx_error            = error_q;
  assign bus.rx_timeout          = timeout_q;

endmodule

// File: tb/tb_usb_host_line_receiver.sv
// Self-checking bench for usb_host_line_receiver: packets are built from payload
// bits by USB rules (stuffing, NRZI, SYNC, EOP) and outputs compared to payloads.
module tb_usb_host_line_receiver;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  usb_host_line_receiver_if bus ();
  usb_host_line_receiver dut (.clock(clock), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  bit got_bits[$];
  int n_start, n_end, n_err, n_tmo;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.serial_data_out_val) got_bits.push_back(bus.serial_data_out);
      if (bus.packet_start) n_start++;
      if (bus.packet_end)   n_end++;
      if (bus.rx_error)     n_err++;
      if (bus.rx_timeout)   n_tmo++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

  function automatic logic [1:0] j_sym();
    return bus.low_speed ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [63:0] pack_bits(input bit q[$]);
    logic [63:0] r = '0;
    foreach (q[i]) r[i] = q[i];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_line(input logic [1:0] l);
    bus.usb_line   = l;
    bus.bit_strobe = 1'b1;
    tick(1);
    bus.bit_strobe = 1'b0;
    tick(2);
  endtask

  task automatic clear_obs();
    got_bits.delete();
    n_start = 0;
    n_end   = 0;
    n_err   = 0;
    n_tmo   = 0;
  endtask

  task automatic start_rx();
    bus.rx_enable = 1'b1;
    tick(2);
  endtask

  task automatic stop_rx();
    bus.rx_enable = 1'b0;
    tick(2);
  endtask

  // Idle J, then SYNC + payload with USB bit stuffing, NRZI on the line, optional EOP.
  task automatic send_packet(input bit payload[$], input bit do_stuff, input bit do_eop);
    bit         raw[$];
    bit         stream[$];
    logic [1:0] level;
    int         ones = 0;
    for (int i = 0; i < 7; i++) raw.push_back(1'b0);
    raw.push_back(1'b1);
    foreach (payload[i]) raw.push_back(payload[i]);
    foreach (raw[i]) begin
      stream.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (do_stuff && ones == 6) begin
        stream.push_back(1'b0);
        ones = 0;
      end
    end
    level = j_sym();
    repeat (3) send_line(level);
    foreach (stream[i]) begin
      if (!stream[i]) level = ~level;
      send_line(level);
    end
    if (do_eop) begin
      send_line(2'b00);
      send_line(2'b00);
      send_line(j_sym());
    end
  endtask

  task automatic test_reset();
    bus.bit_strobe = 1'b0;
    bus.rx_enable  = 1'b1;
    bus.low_speed  = 1'b0;
    bus.usb_line   = 2'b10;
    reset = 1'b1;
    tick(3);
    checks++;
    if ({bus.serial_data_out, bus.serial_data_out_val, bus.packet_start, bus.packet_end,
         bus.rx_active, bus.rx_error, bus.rx_timeout} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {bus.serial_data_out, bus.serial_data_out_val, bus.packet_start,
                bus.packet_end, bus.rx_active, bus.rx_error, bus.rx_timeout});
    end
    bus.rx_enable = 1'b0;
    reset = 1'b0;
    tick(2);
    checks++;
    if (bus.rx_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_active: got %b required 0", bus.rx_active);
    end
  endtask

  task automatic test_basic_packet(input bit ls);
    bit p[$];
    logic [7:0] b = 8'hA5;
    bus.low_speed = ls;
    clear_obs();
    start_rx();
    for (int i = 0; i < 8; i++) p.push_back(b[i]);
    send_packet(p, 1'b1, 1'b1);
    checks++;
    if (n_start != 1) begin
      errors++; $display("FAIL basic_start ls=%0d: got %0d required 1", ls, n_start);
    end
    checks++;
    if (got_bits.size() != 8 || pack_bits(got_bits) !== 64'hA5) begin
      errors++;
      $display("FAIL basic_data ls=%0d: got %0d bits %h required 8 bits a5",
               ls, got_bits.size(), pack_bits(got_bits));
    end
    checks++;
    if (n_end != 1 || n_err != 0) begin
      errors++; $display("FAIL basic_end ls=%0d: got end=%0d err=%0d required end=1 err=0", ls, n_end, n_err);
    end
    checks++;
    if (bus.rx_active !== 1'b0) begin
      errors++; $display("FAIL basic_active ls=%0d: got %b required 0", ls, bus.rx_active);
    end
    stop_rx();
    bus.low_speed = 1'b0;
  endtask

  task automatic test_stuffing();
    bit p[$];
    logic [15:0] w = 16'h00FF;
    clear_obs();
    start_rx();
    for (int i = 0; i < 16; i++) p.push_back(w[i]);
    send_packet(p, 1'b1, 1'b1);
    checks++;
    if (got_bits.size() != 16 || pack_bits(got_bits) !== 64'h00FF) begin
      errors++;
      $display("FAIL stuff_data: got %0d bits %h required 16 bits 00ff",
               got_bits.size(), pack_bits(got_bits));
    end
    checks++;
    if (n_end != 1 || n_err != 0) begin
      errors++; $display("FAIL stuff_end: got end=%0d err=%0d required end=1 err=0", n_end, n_err);
    end
    stop_rx();
  endtask

  task automatic test_stuff_error();
    bit p[$];
    bit q[$];
    logic [7:0] b = 8'h3C;
    clear_obs();
    start_rx();
    for (int i = 0; i < 8; i++) p.push_back(1'b1);
    send_packet(p, 1'b0, 1'b1);
    checks++;
    if (got_bits.size() != 5 || pack_bits(got_bits) !== 64'h1F) begin
      errors++;
      $display("FAIL stuferr_data: got %0d bits %h required 5 bits 1f",
               got_bits.size(), pack_bits(got_bits));
    end
    checks++;
    if (n_err != 1 || n_end != 0) begin
      errors++; $display("FAIL stuferr_flags: got err=%0d end=%0d required err=1 end=0", n_err, n_end);
    end
    checks++;
    if (bus.rx_active !== 1'b0) begin
      errors++; $display("FAIL stuferr_active: got %b required 0", bus.rx_active);
    end
    // Still enabled: the receiver must stay parked and ignore a valid packet.
    clear_obs();
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
    send_packet(q, 1'b1, 1'b1);
    checks++;
    if (n_start != 0 || got_bits.size() != 0 || n_end != 0) begin
      errors++;
      $display("FAIL stuferr_hold: got start=%0d bits=%0d end=%0d required 0 0 0",
               n_start, got_bits.size(), n_end);
    end
    stop_rx();
    clear_obs();
    start_rx();
    send_packet(q, 1'b1, 1'b1);
    checks++;
    if (n_end != 1 || pack_bits(got_bits) !== 64'h3C) begin
      errors++;
      $display("FAIL stuferr_recover: got end=%0d data %h required end=1 data 3c",
               n_end, pack_bits(got_bits));
    end
    stop_rx();
  endtask

  task automatic test_timeout();
    clear_obs();
    start_rx();
    repeat (15) send_line(j_sym());
    checks++;
    if (n_tmo != 0) begin
      errors++; $display("FAIL timeout_early: got %0d pulses required 0", n_tmo);
    end
    bus.usb_line   = j_sym();
    bus.bit_strobe = 1'b1;
    @(posedge clock);
    #1;
    bus.bit_strobe = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.rx_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_pulse: got %b required 1", bus.rx_timeout);
    end
    tick(3);
    checks++;
    if (n_tmo != 1 || n_err != 0 || bus.rx_active !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: got tmo=%0d err=%0d active=%b required 1 0 0",
               n_tmo, n_err, bus.rx_active);
    end
    stop_rx();
  endtask

  task automatic test_abort();
    bit p[$];
    bit exp_bits[$];
    clear_obs();
    start_rx();
    for (int i = 0; i < 3; i++) p.push_back(1'($urandom_range(0, 1)));
    exp_bits = p;
    send_packet(p, 1'b1, 1'b0);
    checks++;
    if (bus.rx_active !== 1'b1 || got_bits.size() != 3 || pack_bits(got_bits) !== pack_bits(exp_bits)) begin
      errors++;
      $display("FAIL abort_before: got active=%b bits=%0d data %h required 1 3 %h",
               bus.rx_active, got_bits.size(), pack_bits(got_bits), pack_bits(exp_bits));
    end
    // Drop rx_enable in the same cycle as an SE1 strobe: abort must win.
    bus.rx_enable  = 1'b0;
    bus.usb_line   = 2'b11;
    bus.bit_strobe = 1'b1;
    @(posedge clock);
    #1;
    bus.bit_strobe = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.rx_active !== 1'b0) begin
      errors++; $display("FAIL abort_active: got %b required 0", bus.rx_active);
    end
    tick(4);
    checks++;
    if (n_end != 0 || n_err != 0 || got_bits.size() != 3) begin
      errors++;
      $display("FAIL abort_quiet: got end=%0d err=%0d bits=%0d required 0 0 3",
               n_end, n_err, got_bits.size());
    end
  endtask

  task automatic test_length();
    bit p[$];
    clear_obs();
    start_rx();
    for (int i = 0; i < 12; i++) p.push_back(1'($urandom_range(0, 1)));
    send_packet(p, 1'b1, 1'b1);
    checks++;
    if (got_bits.size() != 12 || pack_bits(got_bits) !== pack_bits(p)) begin
      errors++;
      $display("FAIL len12_data: got %0d bits %h required 12 bits %h",
               got_bits.size(), pack_bits(got_bits), pack_bits(p));
    end
    checks++;
    if (n_err != 1 || n_end != 0) begin
      errors++; $display("FAIL len12_flags: got err=%0d end=%0d required err=1 end=0", n_err, n_end);
    end
    stop_rx();
  endtask

  task automatic test_reset_mid_packet();
    bit p[$];
    clear_obs();
    start_rx();
    for (int i = 0; i < 5; i++) p.push_back(1'($urandom_range(0, 1)));
    send_packet(p, 1'b1, 1'b0);
    reset = 1'b1;
    tick(1);
    checks++;
    if (bus.rx_active !== 1'b0 || bus.rx_error !== 1'b0 || bus.packet_end !== 1'b0) begin
      errors++;
      $display("FAIL midreset_out: got active=%b err=%b end=%b required 0 0 0",
               bus.rx_active, bus.rx_error, bus.packet_end);
    end
    tick(2);
    bus.rx_enable = 1'b0;
    reset = 1'b0;
    tick(3);
    checks++;
    if (n_end != 0 || n_err != 0) begin
      errors++; $display("FAIL midreset_pulses: got end=%0d err=%0d required 0 0", n_end, n_err);
    end
  endtask

  task automatic test_back_to_back();
    for (int g = 0; g < 4; g++) begin
      bus.low_speed = 1'($urandom_range(0, 1));
      start_rx();
      for (int k = 0; k < 3; k++) begin
        bit p[$];
        int len;
        int exp_end;
        len = ($urandom_range(0, 1) != 0) ? 8 * $urandom_range(1, 3) : $urandom_range(1, 24);
        for (int i = 0; i < len; i++) p.push_back(1'($urandom_range(0, 1)));
        exp_end = (len % 8 == 0) ? 1 : 0;
        clear_obs();
        send_packet(p, 1'b1, 1'b1);
        checks++;
        if (n_start != 1) begin
          errors++; $display("FAIL b2b_start g=%0d k=%0d: got %0d required 1", g, k, n_start);
        end
        checks++;
        if (got_bits.size() != len || pack_bits(got_bits) !== pack_bits(p)) begin
          errors++;
          $display("FAIL b2b_data g=%0d k=%0d: got %0d bits %h required %0d bits %h",
                   g, k, got_bits.size(), pack_bits(got_bits), len, pack_bits(p));
        end
        checks++;
        if (n_end != exp_end || n_err != 1 - exp_end) begin
          errors++;
          $display("FAIL b2b_eop g=%0d k=%0d len=%0d: got end=%0d err=%0d required end=%0d err=%0d",
                   g, k, len, n_end, n_err, exp_end, 1 - exp_end);
        end
      end
      stop_rx();
    end
    bus.low_speed = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_packet(1'b0);
    test_stuffing();
    test_stuff_error();
    test_timeout();
    test_basic_packet(1'b1);
    test_abort();
    test_length();
    test_reset_mid_packet();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
